// File: rtl/btn_evt_pkg.sv
// Shared constants for the button event arbiter: button codes, event record layout
// and the grant priority order.
package btn_evt_pkg;

    localparam int NUM_BTN = 5;
    localparam int CODE_W  = 3;
    localparam int SW_W    = 16;

    localparam logic [CODE_W-1:0] BTN_U = 3'd0;
    localparam logic [CODE_W-1:0] BTN_D = 3'd1;
    localparam logic [CODE_W-1:0] BTN_L = 3'd2;
    localparam logic [CODE_W-1:0] BTN_R = 3'd3;
    localparam logic [CODE_W-1:0] BTN_C = 3'd4;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [SW_W-1:0]   sw;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

    // Highest priority first.
    localparam logic [CODE_W-1:0] PRIO [NUM_BTN] = '{BTN_C, BTN_U, BTN_D, BTN_L, BTN_R};

    // Returns the code of the highest-priority set bit; 0 when none is set.
    function automatic logic [CODE_W-1:0] pick_grant(input logic [NUM_BTN-1:0] pend);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pend[PRIO[i]]) code = PRIO[i];
        end
        return code;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through event queue with occupancy count; head reads 0 when empty.
// Latency: push visible on the output the cycle after; push is accepted when full only with a pop.
module evt_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH):0]     cnt_o,
    output logic                       full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_pop;
    logic          w_push;

    assign w_pop  = pop_i & (r_cnt != '0);
    assign w_push = push_i & ((r_cnt != (AW+1)'(DEPTH)) | w_pop);

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= din_i;
    end

    assign dout_o = (r_cnt == '0) ? '0 : r_mem[r_rptr];
    assign cnt_o  = r_cnt;
    assign full_o = (r_cnt == (AW+1)'(DEPTH));

endmodule

// File: rtl/btn_event_arbiter.sv
// Turns button presses into queued {code, switch snapshot} events, one grant per cycle, C>U>D>L>R.
// Latency: 2 cycles press-to-valid; pending presses wait while the queue is full (build option BTN_EVT_AUTOREPEAT_EN).
module btn_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [4:0]                    btn_i,
    input  logic [15:0]                   sw_i,
    input  logic                          evt_ready_i,
    input  logic                          clr_ovf_i,
    output logic                          evt_valid_o,
    output logic [2:0]                    evt_code_o,
    output logic [15:0]                   evt_sw_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
    output logic                          overflow_o
);
    logic               r_arm;
    logic [NUM_BTN-1:0] r_prev;
    logic [NUM_BTN-1:0] r_pending;
    logic               r_ovf;

    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_rep;
    logic [NUM_BTN-1:0] w_set;
    logic [NUM_BTN-1:0] w_gnt_mask;
    logic [CODE_W-1:0]  w_gnt_code;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_ovf_set;
    evt_t               w_push_evt;
    evt_t               w_head_evt;

    // The first edge after reset only loads prev, so a button held through reset is not a press.
    assign w_press    = r_arm ? (btn_i & ~r_prev) : '0;
    assign w_gnt_code = pick_grant(r_pending);
    assign w_pop      = evt_valid_o & evt_ready_i;
    assign w_push     = (|r_pending) & (~w_full | w_pop);
    assign w_gnt_mask = w_push ? (5'b00001 << w_gnt_code) : '0;
    assign w_set      = w_press | w_rep;
    assign w_ovf_set  = |(w_set & r_pending & ~w_gnt_mask);
    assign w_push_evt = '{code: w_gnt_code, sw: sw_i};

`ifdef BTN_EVT_AUTOREPEAT_EN
    localparam int RCW = $clog2(REPEAT_DELAY + 1);

    for (genvar k = 0; k < NUM_BTN; k++) begin : g_rep
        logic [RCW-1:0] r_rcnt;

        assign w_rep[k] = btn_i[k] & (r_rcnt == RCW'(REPEAT_DELAY));

        // Counts held clocks from a real press; reloading after each repeat spaces them by REPEAT_PERIOD.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_rcnt <= '0;
            end else if (!btn_i[k]) begin
                r_rcnt <= '0;
            end else if (w_rep[k]) begin
                r_rcnt <= RCW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
            end else if ((r_rcnt != '0) || w_press[k]) begin
                r_rcnt <= r_rcnt + 1'b1;
            end
        end
    end
`else
    assign w_rep = '0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_arm     <= 1'b0;
            r_prev    <= '0;
            r_pending <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_arm     <= 1'b1;
            r_prev    <= btn_i;
            r_pending <= (r_pending & ~w_gnt_mask) | w_set;
            r_ovf     <= (r_ovf & ~clr_ovf_i) | w_ovf_set;
        end
    end

    evt_fifo #(
        .W     (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (w_push),
        .din_i  (w_push_evt),
        .pop_i  (w_pop),
        .dout_o (w_head_evt),
        .cnt_o  (fifo_cnt_o),
        .full_o (w_full)
    );

    assign evt_valid_o = (fifo_cnt_o != '0);
    assign evt_code_o  = w_head_evt.code;
    assign evt_sw_o    = w_head_evt.sw;
    assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter: directed vector table, hand sequences for reset and
// hold behaviour, then random stimulus against a queue-based reference model.
module tb_btn_event_arbiter;
    localparam int DEPTH = 4;
    localparam int RD    = 20;
    localparam int RP    = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  btn = '0;
    logic [15:0] sw  = '0;
    logic        rdy = 1'b0;
    logic        clr = 1'b0;
    logic        vld;
    logic [2:0]  code;
    logic [15:0] esw;
    logic [2:0]  cnt;
    logic        ovf;

    always #5 clk = ~clk;

    btn_event_arbiter #(
        .FIFO_DEPTH    (DEPTH),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_i       (btn),
        .sw_i        (sw),
        .evt_ready_i (rdy),
        .clr_ovf_i   (clr),
        .evt_valid_o (vld),
        .evt_code_o  (code),
        .evt_sw_o    (esw),
        .fifo_cnt_o  (cnt),
        .overflow_o  (ovf)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic e_vld, input logic [2:0] e_code,
                           input logic [15:0] e_sw, input logic [2:0] e_cnt, input logic e_ovf);
        chk({tag, ".valid"}, 32'(vld), 32'(e_vld));
        chk({tag, ".code"},  32'(code), 32'(e_code));
        chk({tag, ".sw"},    32'(esw), 32'(e_sw));
        chk({tag, ".cnt"},   32'(cnt), 32'(e_cnt));
        chk({tag, ".ovf"},   32'(ovf), 32'(e_ovf));
    endtask

    typedef struct {
        logic [4:0]  btn;
        logic [15:0] sw;
        logic        rdy;
        logic        clr;
        logic        e_vld;
        logic [2:0]  e_code;
        logic [15:0] e_sw;
        logic [2:0]  e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t tbl [18];

    // Reference model: pending set, event queue, sticky loss flag, hold lengths.
    logic        m_arm;
    logic [4:0]  m_prev;
    logic [4:0]  m_pend;
    logic        m_ovf;
    logic [18:0] m_q [$];
    int          m_hold [5];
    int          prio_list [5] = '{4, 0, 1, 2, 3};

    task automatic model_reset();
        m_arm = 1'b0; m_prev = '0; m_pend = '0; m_ovf = 1'b0;
        m_q.delete();
        for (int k = 0; k < 5; k++) m_hold[k] = 0;
    endtask

    task automatic model_edge(input logic [4:0] b, input logic [15:0] s, input logic r, input logic c);
        logic [4:0] press, rep, taken;
        bit         pop, push;
        int         gnt;
        press = m_arm ? (b & ~m_prev) : 5'b0;
        rep   = '0;
`ifdef BTN_EVT_AUTOREPEAT_EN
        for (int k = 0; k < 5; k++) begin
            if (b[k] && (m_hold[k] > 0 || press[k])) begin
                if (m_hold[k] >= RD && ((m_hold[k] - RD) % RP) == 0) rep[k] = 1'b1;
                m_hold[k]++;
            end else if (!b[k]) begin
                m_hold[k] = 0;
            end
        end
`endif
        pop = r && (m_q.size() > 0);
        gnt = -1;
        for (int i = 4; i >= 0; i--) if (m_pend[prio_list[i]]) gnt = prio_list[i];
        push  = (gnt >= 0) && ((m_q.size() < DEPTH) || pop);
        taken = push ? (5'b1 << gnt) : 5'b0;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back({3'(gnt), s});
            m_pend[gnt] = 1'b0;
        end
        m_ovf  = (m_ovf && !c) || (((press | rep) & m_pend & ~taken) != 0);
        m_pend = m_pend | press | rep;
        m_prev = b;
        m_arm  = 1'b1;
    endtask

    initial begin
        int ev[$];
        int exp_ev[$];
        int nvld;
        logic [18:0] head;

        tbl[0]  = '{5'h00, 16'h1111, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b0};
        tbl[1]  = '{5'h15, 16'h1111, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b0};
        tbl[2]  = '{5'h15, 16'h2222, 1'b0, 1'b0, 1'b1, 3'd4, 16'h2222, 3'd1, 1'b0};
        tbl[3]  = '{5'h15, 16'h3333, 1'b0, 1'b0, 1'b1, 3'd4, 16'h2222, 3'd2, 1'b0};
        tbl[4]  = '{5'h15, 16'h4444, 1'b0, 1'b0, 1'b1, 3'd4, 16'h2222, 3'd3, 1'b0};
        tbl[5]  = '{5'h1F, 16'h5555, 1'b0, 1'b0, 1'b1, 3'd4, 16'h2222, 3'd3, 1'b0};
        tbl[6]  = '{5'h1F, 16'h6666, 1'b0, 1'b0, 1'b1, 3'd4, 16'h2222, 3'd4, 1'b0};
        tbl[7]  = '{5'h1F, 16'h7777, 1'b0, 1'b0, 1'b1, 3'd4, 16'h2222, 3'd4, 1'b0};
        tbl[8]  = '{5'h17, 16'h7777, 1'b0, 1'b0, 1'b1, 3'd4, 16'h2222, 3'd4, 1'b0};
        tbl[9]  = '{5'h1F, 16'h7777, 1'b0, 1'b0, 1'b1, 3'd4, 16'h2222, 3'd4, 1'b1};
        tbl[10] = '{5'h1F, 16'h8888, 1'b1, 1'b0, 1'b1, 3'd0, 16'h3333, 3'd4, 1'b1};
        tbl[11] = '{5'h1F, 16'h9999, 1'b1, 1'b0, 1'b1, 3'd2, 16'h4444, 3'd3, 1'b1};
        tbl[12] = '{5'h1F, 16'h9999, 1'b0, 1'b1, 1'b1, 3'd2, 16'h4444, 3'd3, 1'b0};
        tbl[13] = '{5'h1F, 16'h9999, 1'b1, 1'b0, 1'b1, 3'd1, 16'h6666, 3'd2, 1'b0};
        tbl[14] = '{5'h1F, 16'h9999, 1'b1, 1'b0, 1'b1, 3'd3, 16'h8888, 3'd1, 1'b0};
        tbl[15] = '{5'h1F, 16'h9999, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b0};
        tbl[16] = '{5'h00, 16'h9999, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b0};
        tbl[17] = '{5'h00, 16'h9999, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b0};

        // Reset state, with inputs active to show they are ignored.
        btn = 5'h1F; sw = 16'hFFFF; rdy = 1'b1;
        tick(); tick();
        chk_out("reset", 1'b0, 3'd0, 16'h0000, 3'd0, 1'b0);
        btn = '0; rdy = 1'b0;
        tick();
        rst = 1'b0;

        // Directed table: same-cycle priority, full queue, loss flag, clear.
        for (int i = 0; i < 18; i++) begin
            btn = tbl[i].btn; sw = tbl[i].sw; rdy = tbl[i].rdy; clr = tbl[i].clr;
            tick();
            chk_out($sformatf("tbl%0d", i), tbl[i].e_vld, tbl[i].e_code, tbl[i].e_sw,
                    tbl[i].e_cnt, tbl[i].e_ovf);
        end
        clr = 1'b0;

        // Single press of U, consumer always ready.
        btn = 5'h01; sw = 16'hA5A5; rdy = 1'b1;
        tick();
        chk("single.press_edge_valid", 32'(vld), 32'd0);
        tick();
        chk_out("single.event", 1'b1, 3'd0, 16'hA5A5, 3'd1, 1'b0);
        tick();
        chk("single.after_pop_valid", 32'(vld), 32'd0);
        nvld = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (vld) nvld++; end
        chk("single.no_extra_events", 32'(nvld), 32'd0);
        btn = '0;
        for (int i = 0; i < 3; i++) tick();

        // Hold D for 40 cycles and log the cycles where an event is presented.
`ifdef BTN_EVT_AUTOREPEAT_EN
        exp_ev = '{1, 21, 26, 31, 36};
`else
        exp_ev = '{1};
`endif
        btn = 5'h02; sw = 16'h0D0D;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (vld) begin
                ev.push_back(i);
                chk("hold.code", 32'(code), 32'd1);
            end
        end
        btn = '0;
        nvld = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (vld) nvld++; end
        chk("hold.event_count", 32'(ev.size()), 32'(exp_ev.size()));
        for (int j = 0; j < exp_ev.size() && j < ev.size(); j++)
            chk($sformatf("hold.event%0d_cycle", j), 32'(ev[j]), 32'(exp_ev[j]));
        chk("hold.after_release", 32'(nvld), 32'd0);

        // Reset mid-operation with C held.
        btn = 5'h13; rdy = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rstmid.cnt_before", 32'(cnt), 32'd3);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_out("rstmid.async", 1'b0, 3'd0, 16'h0000, 3'd0, 1'b0);
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        nvld = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (vld) nvld++; end
        chk("rstmid.no_held_event", 32'(nvld), 32'd0);
        btn = '0;
        tick();

        // Random stimulus against the reference model.
        rst = 1'b1;
        tick();
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 5; k++) if ($urandom_range(7) == 0) btn[k] = ~btn[k];
            sw  = 16'($urandom);
            rdy = ($urandom_range(2) == 0);
            clr = ($urandom_range(15) == 0);
            model_edge(btn, sw, rdy, clr);
            tick();
            head = (m_q.size() > 0) ? m_q[0] : 19'd0;
            chk_out($sformatf("rand%0d", i), m_q.size() > 0, head[18:16], head[15:0],
                    3'(m_q.size()), m_ovf);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/btn_event_arbiter.md
BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event queue depth; power of two, 2..16.
REQ-002 SHALL have parameter REPEAT_DELAY, default 50_000_000, hold clocks before the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10_000_000, clocks between subsequent auto-repeats.
REQ-004 clk_i  input  1  sole clock, all logic on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 btn_i  input  5  debounced button levels, bit 0=U, 1=D, 2=L, 3=R, 4=C.
REQ-007 sw_i  input  16  switch levels, snapshotted with each event.
REQ-008 evt_ready_i  input  1  consumer accepts the head event.
REQ-009 clr_ovf_i  input  1  clears overflow_o.
REQ-010 evt_valid_o  output  1  head event available.
REQ-011 evt_code_o  output  3  head event button code, 0..4 = U, D, L, R, C.
REQ-012 evt_sw_o  output  16  sw_i snapshot taken at enqueue.
REQ-013 fifo_cnt_o  output  $clog2(FIFO_DEPTH)+1  queued event count.
REQ-014 overflow_o  output  1  sticky: a press was lost.

Function
REQ-015 SHALL register btn_i into prev[4:0] each cycle; a press is btn_i & ~prev.
REQ-016 SHALL set pending[k] at the edge where a press on button k is sampled.
REQ-017 SHALL, each cycle, grant at most one pending bit by fixed priority C > U > D > L > R, and enqueue {code, sw_i} when the FIFO is not full or a pop occurs in the same cycle.
REQ-018 SHALL clear the granted pending bit on enqueue; a press sampled on a granted bit in the same cycle re-sets it.
REQ-019 SHALL hold non-granted pending bits unchanged while the FIFO is full.
REQ-020 SHALL set overflow_o when a press arrives on a bit that is already pending and not granted that cycle; that press is dropped.
REQ-021 SHALL give 2-cycle latency: press sampled at edge N, enqueued at edge N+1, evt_valid_o high after N+1 when the FIFO was empty and no higher-priority bit was pending.
REQ-022 SHALL provide first-word-fall-through output; evt_valid_o = (fifo_cnt_o != 0).
REQ-023 SHALL pop on evt_valid_o & evt_ready_i; evt_ready_i with an empty FIFO has no effect.
REQ-024 SHALL keep evt_code_o and evt_sw_o stable while evt_valid_o is high and not popped.
REQ-025 SHALL keep fifo_cnt_o unchanged on a simultaneous push and pop, and wrap pointers modulo FIFO_DEPTH.
REQ-026 SHALL clear overflow_o on clr_ovf_i; a set and a clear in the same cycle leaves it set.
REQ-027 SHALL not generate events on button release.

Reset
REQ-028 SHALL, while rst_i is high, clear prev, pending, FIFO pointers, repeat counters and overflow_o.
REQ-029 SHALL drive evt_valid_o=0, fifo_cnt_o=0, overflow_o=0 and evt_code_o/evt_sw_o=0 during reset.
REQ-030 SHALL discard queued events on reset mid-operation; a button held through reset release produces no press.

Configuration
REQ-031 With BTN_EVT_AUTOREPEAT_EN defined: SHALL use one counter per button; pending is set after REPEAT_DELAY held clocks, then every REPEAT_PERIOD clocks; release or reset zeroes the counter.
REQ-032 Without BTN_EVT_AUTOREPEAT_EN: SHALL generate no repeat counters; a held button yields exactly one event.

Structure
REQ-033 SHALL place the button index/code constants (BTN_U..BTN_C), event width and priority order in package btn_evt_pkg.
REQ-034 SHALL implement the queue as sub-module evt_fifo (parameterized width/depth, FWFT, count output).

Verification
REQ-035 Single press U with evt_ready_i=1 -> evt_valid_o high for 1 cycle, 2 cycles after press, code 0, evt_sw_o = sw_i at enqueue (e.g. 16'hA5A5).
REQ-036 U, L, C rising in the same cycle, evt_ready_i=0 -> fifo_cnt_o reaches 3; pop order codes 4, 0, 2.
REQ-037 FIFO_DEPTH=4, ready=0, 5 presses on distinct buttons -> fifo_cnt_o=4, 5th stays pending; after 1 pop it is enqueued; overflow_o=0.
REQ-038 Full FIFO, R pending, second R press -> overflow_o=1; clr_ovf_i pulse -> 0.
REQ-039 rst_i asserted with 3 queued events while C is held -> count 0 and valid 0 immediately; no C event after reset release.
REQ-040 Autorepeat build, REPEAT_DELAY=20, REPEAT_PERIOD=5, hold D 40 cycles, ready=1 -> events at press+2, +22, +27, +32, +37; none after release.
